// File: rtl/muldiv_seq_if.sv
// Request/response handshake bundle between the execute stage and the RV32M multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int DWIDTH = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] result;
    logic              busy;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per clock,
// operating on magnitudes with a final sign-fix cycle.
module muldiv_seq #(
    parameter int DWIDTH = 32,
    parameter int CNT_W  = $clog2(DWIDTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    localparam int AW = 2 * DWIDTH + 1;
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(DWIDTH - 1);
    localparam logic [DWIDTH-1:0] INT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [AW-1:0]     acc_q;
    logic [DWIDTH-1:0] opnd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DWIDTH-1:0] result_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              busy_q;

    // Operand decode for the acceptance edge
    logic              a_sgn, b_sgn, a_neg, b_neg, neg_d;
    logic [DWIDTH-1:0] a_mag, b_mag;
    logic              special_d;
    logic [DWIDTH-1:0] special_res_d;

    always_comb begin
        a_sgn = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_sgn = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        a_neg = a_sgn && bus.a[DWIDTH-1];
        b_neg = b_sgn && bus.b[DWIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
        // Remainder takes the dividend's sign; products and quotients take the XOR
        neg_d = (bus.op == OP_REM) ? a_neg : (a_neg ^ b_neg);

        special_d     = 1'b0;
        special_res_d = '0;
        if (bus.op[2]) begin
            if (bus.b == '0) begin
                special_d     = 1'b1;
                special_res_d = bus.op[1] ? bus.a : '1;
            end else if ((bus.op == OP_DIV || bus.op == OP_REM) &&
                         bus.a == INT_MIN && bus.b == '1) begin
                special_d     = 1'b1;
                special_res_d = bus.op[1] ? '0 : INT_MIN;
            end
        end
    end

    // One iteration of each algorithm; upper half of acc is DWIDTH+1 bits wide
    logic [DWIDTH:0]   mul_sum;
    logic [AW-1:0]     mul_step_d;
    logic [AW-1:0]     div_sh;
    logic [DWIDTH+1:0] div_diff;
    logic [AW-1:0]     div_step_d;

    always_comb begin
        mul_sum    = acc_q[AW-1:DWIDTH] + {1'b0, opnd_q};
        mul_step_d = acc_q[0] ? ({mul_sum, acc_q[DWIDTH-1:0]} >> 1) : (acc_q >> 1);

        div_sh     = {acc_q[AW-2:0], 1'b0};
        div_diff   = {1'b0, div_sh[AW-1:DWIDTH]} - {2'b00, opnd_q};
        div_step_d = div_diff[DWIDTH+1] ? div_sh
                                        : {div_diff[DWIDTH:0], div_sh[DWIDTH-1:1], 1'b1};
    end

    // Sign fix and field select
    logic [2*DWIDTH-1:0] prod_d;
    logic [DWIDTH-1:0]   quo_d, rem_d, fix_res_d;

    always_comb begin
        prod_d = neg_q ? -acc_q[2*DWIDTH-1:0] : acc_q[2*DWIDTH-1:0];
        quo_d  = neg_q ? -acc_q[DWIDTH-1:0] : acc_q[DWIDTH-1:0];
        rem_d  = neg_q ? -acc_q[2*DWIDTH-1:DWIDTH] : acc_q[2*DWIDTH-1:DWIDTH];
        unique case (op_q)
            OP_MUL:                       fix_res_d = prod_d[DWIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_d = prod_d[2*DWIDTH-1:DWIDTH];
            OP_DIV, OP_DIVU:              fix_res_d = quo_d;
            default:                      fix_res_d = rem_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else if (state_q != IDLE && bus.flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && !bus.flush) begin
                        op_q       <= bus.op;
                        neg_q      <= neg_d;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        // Divide iterates on the dividend, multiply on the multiplier
                        acc_q      <= {{(DWIDTH+1){1'b0}}, bus.op[2] ? a_mag : b_mag};
                        opnd_q     <= bus.op[2] ? b_mag : a_mag;
                        if (special_d) begin
                            result_q    <= special_res_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= op_q[2] ? div_step_d : mul_step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= FIX;
                end
                FIX: begin
                    result_q    <= fix_res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected results, a negedge monitor pops on handshake.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    muldiv_seq_if #(.DWIDTH(32)) bus ();

    muldiv_seq #(.DWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a result is consumed on the edge following a negedge with valid&&ready
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", bus.result);
            end else begin
                automatic logic [31:0] e  = exp_q.pop_front();
                automatic string       nm = name_q.pop_front();
                chk(nm, bus.result, e);
            end
        end
    end

    task automatic wait_valid(input string nm, input int lat_exp);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(lat_exp));
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e, input int lat_exp, input string nm);
        int n = 0;
        bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk); #1;
        // Scramble operands: the block must not depend on them being held
        bus.in_valid = 1'b0; bus.op = 3'd7; bus.a = 32'hDEADBEEF; bus.b = 32'h0;
        wait_valid(nm, lat_exp);
        @(posedge clk); #1;
        chk({nm, "_release"}, 32'(bus.out_valid), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3"};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min_min"};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max_max"};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu_m1_2"};
        vecs[4]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33, "divu_100_7"};
        vecs[5]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33, "remu_100_7"};
        vecs[6]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_m7_2"};
        vecs[7]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_m7_2"};
        vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 0,  "div_5_0"};
        vecs[9]  = '{3'd7, 32'd5,        32'd0,        32'd5,        0,  "remu_5_0"};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,  "div_ovf"};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0,  "rem_ovf"};
        vecs[12] = '{3'd5, 32'd9,        32'd0,        32'hFFFFFFFF, 0,  "divu_9_0"};
        vecs[13] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 0,  "rem_m7_0"};

        bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    bus.result,         32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;

        foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].nm);

        // Backpressure: MUL 3*4 held in DONE for 10 cycles
        bus.out_ready = 1'b0;
        bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd4; bus.in_valid = 1'b1;
        exp_q.push_back(32'd12); name_q.push_back("bp_mul_3_4");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_valid("bp_mul", 33);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_result",    bus.result,         32'd12);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        // Next request already waiting while still in DONE; must be taken one edge after release
        bus.op = 3'd0; bus.a = 32'd2; bus.b = 32'd5; bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        exp_q.push_back(32'd10); name_q.push_back("bp_next_mul_2_5");
        @(posedge clk); #1;
        chk("bp_idle_in_ready",  32'(bus.in_ready),  32'd1);
        chk("bp_idle_busy",      32'(bus.busy),      32'd0);
        chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("bp_next_accept_busy", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b0;
        wait_valid("bp_next", 33);
        @(posedge clk); #1;

        // Flush in IDLE blocks acceptance
        bus.op = 3'd0; bus.a = 32'd1; bus.b = 32'd1; bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_idle_busy",     32'(bus.busy),     32'd0);
        chk("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Flush at iteration 10 of DIVU
        bus.op = 3'd5; bus.a = 32'd1000; bus.b = 32'd3; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_calc_busy",      32'(bus.busy),      32'd0);
        chk("flush_calc_in_ready",  32'(bus.in_ready),  32'd1);
        chk("flush_calc_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_calc_result",    bus.result,         32'd10);
        begin
            logic seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                seen = seen | bus.out_valid;
            end
            chk("flush_calc_no_valid", 32'(seen), 32'd0);
        end
        do_op(3'd0, 32'd2, 32'd3, 32'd6, 33, "post_flush_mul_2_3");

        // Flush in DONE discards the held result but result keeps its value
        bus.out_ready = 1'b0;
        bus.op = 3'd5; bus.a = 32'd9; bus.b = 32'd0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("flush_done_pre_valid", 32'(bus.out_valid), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_done_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_done_busy",      32'(bus.busy),      32'd0);
        chk("flush_done_result",    bus.result,         32'hFFFFFFFF);
        bus.out_ready = 1'b1;

        // Reset mid-CALC
        bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_result",    bus.result,         32'd0);
        chk("rst_mid_busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;
        do_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "post_rst_remu");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage.
- It accepts one operation over a valid/ready handshake, computes it with shift-add (multiply) or restoring shift-subtract (divide), and returns one result over a valid/ready handshake.
- The pipeline stalls on in_ready/out_valid. flush aborts the operation in flight on a branch mispredict or trap.

Parameters:
DWIDTH, 32, operand and result width
CNT_W, $clog2(DWIDTH)+1, width of the iteration counter

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  high only in IDLE
op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  input  DWIDTH  rs1 operand
b  input  DWIDTH  rs2 operand
flush  input  1  abort operation in flight, discard result
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  DWIDTH  operation result
busy  output  1  high in any state except IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, counter=0. Reset mid-operation discards all work.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Operands are accepted on an edge where in_valid&&in_ready (acceptance edge E0).
  - At E0 the block latches op, sign flags and |a|,|b|. Signed magnitudes are used for MULH/DIV/REM, and for a only in MULHSU.
  - Also at E0: clears the 2*DWIDTH accumulator, counter=0, goes to CALC.
- Special divide cases detected at E0 go straight to DONE with out_valid=1 after E0 (1-cycle latency):
  - b==0, DIV/DIVU: result=all ones.
  - b==0, REM/REMU: result=a.
  - DIV with a==0x80000000, b==0xFFFFFFFF: result=0x80000000.
  - REM with the same operands: result=0.
- CALC: one iteration per edge.
  - Multiply: if multiplier LSB set, add multiplicand to the upper accumulator half, then shift right 1.
  - Divide: shift remainder/quotient left 1, trial-subtract the divisor, keep the result if nonnegative and set the quotient LSB.
  - Counter increments. After the DWIDTH-th iteration (edge E32) go to FIX.
- FIX, one edge (E33):
  - Negate the product if operand signs differ.
  - Negate the quotient if dividend and divisor signs differ.
  - Negate the remainder if the dividend is negative.
  - Select the field: low half for MUL, high half for MULH*, quotient for DIV*, remainder for REM*.
  - Register result, set out_valid=1, go to DONE.
- Normal latency: out_valid first high after E33.
- DONE:
  - result and out_valid are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE.
  - in_ready is 0 in DONE; there is no same-cycle re-accept, so the next accept is at the earliest one edge after the output handshake.
- flush: on any edge with flush=1 in CALC, FIX or DONE, go to IDLE with out_valid=0; result holds its last value.
  - flush has priority over out_ready and over iteration.
  - flush in IDLE blocks acceptance on that edge: flush has priority over in_valid.
- in_valid while busy is ignored; the operands need not be held.
- All arithmetic is modulo 2^DWIDTH; the accumulator is 2*DWIDTH+1 bits to hold the subtract borrow.

Test Plan:
- MUL a=7, b=0xFFFFFFFD → result=0xFFFFFFEB; out_valid first high exactly 33 edges after acceptance.
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIVU 100/7 → 14; REMU → 2. DIV 0xFFFFFFF9(-7)/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- Divide by zero and overflow, all with 1-edge latency:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Backpressure: MUL 3*4 with out_ready=0 for 10 cycles → out_valid and result=12 stable, in_ready=0 throughout. out_ready=1 → back to IDLE; the next in_valid is accepted one edge later.
- Abort: flush at iteration 10 of DIVU → IDLE next edge, out_valid never rises, the next op (MUL 2*3=6) is correct. rst asserted mid-CALC → all outputs at reset values after the edge.
